// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry constants and FSM state type shared by the data cache
package dcache_pkg;
    localparam int WIDTH = 32;
    localparam int SETS = 64;
    localparam int LINE_WORDS = 4;
    localparam int OFF_W = 2;
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WIDTH - IDX_W - WORD_W - OFF_W;
    typedef enum logic [1:0] {IDLE, REFILL, WRITE} dcache_state_t;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage with combinational read and synchronous byte-enabled writes
module dcache_array
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   rd_idx,
    input  logic [WORD_W-1:0]  rd_word,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [WIDTH-1:0]   rd_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [WORD_W-1:0]  wr_word,
    input  logic [3:0]         wr_be,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               tag_we,
    input  logic [IDX_W-1:0]   tag_idx,
    input  logic [TAG_W-1:0]   tag_data,
    input  logic               tag_valid
);
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [WIDTH-1:0] data [SETS*LINE_WORDS];

    assign rd_valid = valid[rd_idx];
    assign rd_tag = tags[rd_idx];
    assign rd_data = data[{rd_idx, rd_word}];

    always_ff @(posedge clk) begin
        if (rst)
            valid <= '0;
        else if (tag_we)
            valid[tag_idx] <= tag_valid;
    end

    always_ff @(posedge clk) begin
        if (tag_we)
            tags[tag_idx] <= tag_data;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            for (int b = 0; b < 4; b++)
                if (wr_be[b])
                    data[{wr_idx, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
    end
endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped write-through no-write-allocate data cache with line refill FSM
module dcache
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [3:0]       cpu_be,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);
    localparam logic [WORD_W-1:0] LAST = WORD_W'(LINE_WORDS - 1);

    dcache_state_t     state, state_n;
    logic [WORD_W-1:0] cnt;
    logic [TAG_W-1:0]  ltag, rd_tag;
    logic [IDX_W-1:0]  lidx, wr_idx;
    logic [WORD_W-1:0] wr_word;
    logic [3:0]        wr_be;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_valid, hit, wr_en, tag_we, tag_valid;

    wire [TAG_W-1:0]  a_tag = cpu_addr[WIDTH-1 -: TAG_W];
    wire [IDX_W-1:0]  a_idx = cpu_addr[OFF_W+WORD_W +: IDX_W];
    wire [WORD_W-1:0] a_word = cpu_addr[OFF_W +: WORD_W];

    assign hit = cpu_req & rd_valid & (rd_tag == a_tag);

    dcache_array u_array (
        .clk(clk), .rst(rst),
        .rd_idx(a_idx), .rd_word(a_word),
        .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_data(cpu_rdata),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_word(wr_word), .wr_be(wr_be), .wr_data(wr_data),
        .tag_we(tag_we), .tag_idx(lidx), .tag_data(ltag), .tag_valid(tag_valid)
    );

    always_comb begin
        state_n = state;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr = {ltag, lidx, cnt, 2'b00};
        mem_be = 4'hf;
        mem_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        wr_en = 1'b0;
        wr_idx = lidx;
        wr_word = cnt;
        wr_be = 4'hf;
        wr_data = mem_rdata;
        tag_we = 1'b0;
        tag_valid = 1'b0;
        if (state == IDLE) begin
            cpu_stall = cpu_req & (cpu_we | ~hit);
            state_n = !cpu_req ? IDLE : cpu_we ? WRITE : hit ? IDLE : REFILL;
        end else if (state == REFILL) begin
            mem_req = 1'b1;
            cpu_stall = 1'b1;
            wr_en = mem_ack;
            // first word invalidates the line, last word publishes it
            tag_we = mem_ack & ((cnt == '0) | (cnt == LAST));
            tag_valid = cnt == LAST;
            state_n = (mem_ack && cnt == LAST) ? IDLE : REFILL;
        end else begin
            mem_req = 1'b1;
            mem_we = 1'b1;
            mem_addr = cpu_addr & ~WIDTH'(3);
            mem_be = cpu_be;
            cpu_stall = ~mem_ack;
            wr_en = mem_ack & hit;
            wr_idx = a_idx;
            wr_word = a_word;
            wr_be = cpu_be;
            wr_data = cpu_wdata;
            state_n = mem_ack ? IDLE : WRITE;
        end
        if (rst) begin
            state_n = IDLE;
            mem_req = 1'b0;
            mem_we = 1'b0;
            cpu_stall = 1'b0;
            wr_en = 1'b0;
            tag_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
        if (rst || state == IDLE)
            cnt <= '0;
        else if (state == REFILL && mem_ack)
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cpu_req && !cpu_we) begin
            ltag <= a_tag;
            lidx <= a_idx;
        end
    end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed self-checking bench for dcache against a word-addressed memory model
module tb_dcache;
    logic        clk = 0, rst = 1, cpu_req = 0, cpu_we = 0, mem_ack = 1;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, mem_rdata;
    logic [3:0]  cpu_be = 0;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata;
    logic        cpu_stall, mem_req, mem_we;
    logic [3:0]  mem_be;

    int total = 0, bad = 0, wr_cnt = 0, st, base;
    logic [31:0] d, wr_addr;
    logic [3:0]  wr_be_l;
    logic [31:0] mem [0:4095];
    logic [4095:0] wrt = '0;
    logic [31:0] rd_log [$];

    dcache dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // unwritten words read back as 0x1000_0000 | byte address
    assign mem_rdata = wrt[mem_addr[13:2]] ? mem[mem_addr[13:2]] : (32'h1000_0000 | {18'd0, mem_addr[13:2], 2'b00});

    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    mem[mem_addr[13:2]][8*b +: 8] <= mem_be[b] ? mem_wdata[8*b +: 8] : mem_rdata[8*b +: 8];
                wrt[mem_addr[13:2]] <= 1'b1;
                wr_cnt++;
                wr_addr = mem_addr;
                wr_be_l = mem_be;
            end else
                rd_log.push_back(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic acc(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                       output int stalls, output logic [31:0] data);
        @(negedge clk);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_be = be; cpu_wdata = wd;
        stalls = 0;
        #1;
        while (cpu_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        data = cpu_rdata;
        @(posedge clk);
        #1;
        cpu_req = 0; cpu_we = 0;
    endtask

    initial begin
        @(negedge clk);
        #1;
        check("rst_stall", {31'd0, cpu_stall}, 0);
        check("rst_mem_req", {31'd0, mem_req}, 0);
        @(negedge clk);
        rst = 0;

        acc(0, 32'h100, 4'h0, 0, st, d);
        check("cold_stalls", st, 5);
        check("cold_data", d, 32'h1000_0100);
        check("cold_nreads", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            check($sformatf("cold_rd%0d", i), rd_log[i], 32'h100 + 32'(4 * i));

        acc(0, 32'h108, 4'h0, 0, st, d);
        check("hit_stalls", st, 0);
        check("hit_data", d, 32'h1000_0108);
        check("hit_nreads", rd_log.size(), 4);

        acc(1, 32'h104, 4'b0001, 32'h0000_00AB, st, d);
        check("sth_stalls", st, 1);
        check("sth_wrcnt", wr_cnt, 1);
        check("sth_addr", wr_addr, 32'h104);
        check("sth_be", {28'd0, wr_be_l}, 32'h1);
        acc(0, 32'h104, 4'h0, 0, st, d);
        check("sth_ld_stalls", st, 0);
        check("sth_ld_data", d, 32'h1000_01AB);

        acc(1, 32'h2000, 4'hf, 32'hDEAD_BEEF, st, d);
        check("stm_stalls", st, 1);
        check("stm_wrcnt", wr_cnt, 2);
        acc(0, 32'h2000, 4'h0, 0, st, d);
        check("stm_ld_stalls", st, 5);
        check("stm_ld_data", d, 32'hDEAD_BEEF);

        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        base = rd_log.size();
        acc(0, 32'h100, 4'h0, 0, st, d);
        check("cf1_stalls", st, 5);
        check("cf1_data", d, 32'h1000_0100);
        acc(0, 32'h500, 4'h0, 0, st, d);
        check("cf2_stalls", st, 5);
        check("cf2_data", d, 32'h1000_0500);
        acc(0, 32'h100, 4'h0, 0, st, d);
        check("cf3_stalls", st, 5);
        check("cf3_data", d, 32'h1000_0100);
        check("cf_nreads", rd_log.size() - base, 12);

        base = rd_log.size();
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h300;
        for (int n = 0; n < 50 && rd_log.size() < base + 2; n++)
            @(negedge clk);
        check("mid_acks", rd_log.size() - base, 2);
        rst = 1; cpu_req = 0;
        #1;
        check("mid_rst_req", {31'd0, mem_req}, 0);
        check("mid_rst_stall", {31'd0, cpu_stall}, 0);
        @(negedge clk);
        rst = 0;
        #1;
        check("mid_after_req", {31'd0, mem_req}, 0);
        check("mid_no_ack", rd_log.size() - base, 2);
        base = rd_log.size();
        acc(0, 32'h300, 4'h0, 0, st, d);
        check("re300_stalls", st, 5);
        check("re300_data", d, 32'h1000_0300);
        check("re300_nreads", rd_log.size() - base, 4);
        acc(0, 32'h100, 4'h0, 0, st, d);
        check("re100_stalls", st, 5);
        check("re100_data", d, 32'h1000_0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
